// File: rtl/adc_spi_responder.sv
// ADC-side SPI responder for a 12-bit converter in SPI mode (0,0).
// The master clocks in a start bit followed by SGL/DIFF and D2..D0. The block
// requests a conversion, then shifts out a null bit and the 12 result bits,
// MSB first.
// The SPI pins are oversampled on clk, which must run at least 8x SCLK.
//
// state        | meaning
// -------------+--------------------------------------------------------------
// S_IDLE       | chip not selected; waiting for synchronized cs_n low
// S_WAIT_START | selected; SCLK rises with din=0 are ignored until the start bit
// S_CMD        | sampling SGL, D2, D1, D0 on four SCLK rises
// S_NULL       | conversion requested; the next SCLK fall drives the null bit
// S_DATA       | driving B11..B0 on successive SCLK falls
// S_TRAIL      | result done; dout held low, further SCLK edges ignored
`timescale 1ns/1ps

module adc_spi_responder #(
    parameter int SYNC_STAGES = 2       // at least 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        spi_sclk,
    input  logic        spi_cs_n,
    input  logic        spi_din,
    output logic        spi_dout,
    output logic        spi_dout_oe,
    output logic [2:0]  ch_sel,
    output logic        sgl_diff,
    output logic        sample_req,
    input  logic [11:0] sample_data,
    output logic        busy,
    output logic        frame_done,
    output logic        frame_err
);

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_WAIT_START = 3'd1,
        S_CMD        = 3'd2,
        S_NULL       = 3'd3,
        S_DATA       = 3'd4,
        S_TRAIL      = 3'd5
    } state_t;

    // ---------------------------------------------------------------
    // Pin synchronizers and SCLK edge detection
    // ---------------------------------------------------------------
    logic [SYNC_STAGES-1:0] r_sclk_sync;
    logic [SYNC_STAGES-1:0] r_cs_sync;
    logic [SYNC_STAGES-1:0] r_din_sync;
    logic                   r_sclk_d;

    // r_fill marks when the synchronizer chains hold real pin samples
    // rather than their reset values. r_armed records that cs_n has been
    // seen high since reset.
    logic [SYNC_STAGES-1:0] r_fill;
    logic                   r_armed;

    logic w_sclk;
    logic w_cs_n;
    logic w_din;
    logic w_sclk_rise;
    logic w_sclk_fall;
    logic w_sync_valid;

    assign w_sclk       = r_sclk_sync[SYNC_STAGES-1];
    assign w_cs_n       = r_cs_sync[SYNC_STAGES-1];
    assign w_din        = r_din_sync[SYNC_STAGES-1];
    assign w_sclk_rise  =  w_sclk & ~r_sclk_d;
    assign w_sclk_fall  = ~w_sclk &  r_sclk_d;
    assign w_sync_valid = r_fill[SYNC_STAGES-1];

    // Shift the pins through the synchronizer chains and keep a one-clk
    // delayed SCLK for edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sclk_sync <= '0;
            r_cs_sync   <= '1;
            r_din_sync  <= '0;
            r_sclk_d    <= 1'b0;
        end else begin
            r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], spi_sclk};
            r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0],   spi_cs_n};
            r_din_sync  <= {r_din_sync[SYNC_STAGES-2:0],  spi_din};
            r_sclk_d    <= w_sclk;
        end
    end

    // After reset, do not trust the synchronized cs_n until the chain has
    // refilled. Arm frame detection only when a real high has been seen.
    // This way a cs_n held low across reset cannot start a frame mid-stream.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fill  <= '0;
            r_armed <= 1'b0;
        end else begin
            r_fill <= {r_fill[SYNC_STAGES-2:0], 1'b1};
            if (w_sync_valid && w_cs_n) begin
                r_armed <= 1'b1;
            end
        end
    end

    // ---------------------------------------------------------------
    // Frame state machine
    // ---------------------------------------------------------------
    state_t      r_state;
    state_t      w_state_nxt;
    logic [3:0]  r_bit_cnt;
    logic [3:0]  w_bit_cnt_nxt;
    logic [2:0]  r_cmd;
    logic [2:0]  w_cmd_nxt;
    logic [11:0] r_shift;
    logic [11:0] w_shift_nxt;
    logic        r_dout;
    logic        w_dout_nxt;
    logic        r_oe;
    logic        w_oe_nxt;
    logic [2:0]  r_ch_sel;
    logic [2:0]  w_ch_sel_nxt;
    logic        r_sgl;
    logic        w_sgl_nxt;
    logic        r_done;
    logic        w_done_nxt;
    logic        r_err;
    logic        w_err_nxt;
    logic        w_sample_req;

    // Register the state and every datapath value that the next-state
    // logic computes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_bit_cnt <= '0;
            r_cmd     <= '0;
            r_shift   <= '0;
            r_dout    <= 1'b0;
            r_oe      <= 1'b0;
            r_ch_sel  <= '0;
            r_sgl     <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_bit_cnt <= w_bit_cnt_nxt;
            r_cmd     <= w_cmd_nxt;
            r_shift   <= w_shift_nxt;
            r_dout    <= w_dout_nxt;
            r_oe      <= w_oe_nxt;
            r_ch_sel  <= w_ch_sel_nxt;
            r_sgl     <= w_sgl_nxt;
            r_done    <= w_done_nxt;
            r_err     <= w_err_nxt;
        end
    end

    // Next-state and datapath decisions. A cs_n release overrides any
    // SCLK edge seen in the same clk.
    always_comb begin
        w_state_nxt   = r_state;
        w_bit_cnt_nxt = r_bit_cnt;
        w_cmd_nxt     = r_cmd;
        w_shift_nxt   = r_shift;
        w_dout_nxt    = r_dout;
        w_oe_nxt      = r_oe;
        w_ch_sel_nxt  = r_ch_sel;
        w_sgl_nxt     = r_sgl;
        w_done_nxt    = 1'b0;
        w_err_nxt     = 1'b0;
        w_sample_req  = 1'b0;

        if ((r_state != S_IDLE) && w_cs_n) begin
            w_state_nxt   = S_IDLE;
            w_bit_cnt_nxt = '0;
            w_dout_nxt    = 1'b0;
            w_oe_nxt      = 1'b0;
            // B0 moves the machine to S_TRAIL, so S_DATA always means the
            // result was cut short.
            if (r_state == S_TRAIL) begin
                w_done_nxt = 1'b1;
            end else if (r_state inside {S_CMD, S_NULL, S_DATA}) begin
                w_err_nxt = 1'b1;
            end
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (!w_cs_n && r_armed) begin
                        w_state_nxt   = S_WAIT_START;
                        w_bit_cnt_nxt = '0;
                    end
                end

                S_WAIT_START: begin
                    if (w_sclk_rise && w_din) begin
                        w_state_nxt   = S_CMD;
                        w_bit_cnt_nxt = '0;
                    end
                end

                S_CMD: begin
                    if (w_sclk_rise) begin
                        if (r_bit_cnt == 4'd3) begin
                            // D0 is on din now. r_cmd holds {SGL, D2, D1}.
                            w_sample_req  = 1'b1;
                            w_sgl_nxt     = r_cmd[2];
                            w_ch_sel_nxt  = {r_cmd[1:0], w_din};
                            w_shift_nxt   = sample_data;
                            w_bit_cnt_nxt = '0;
                            w_state_nxt   = S_NULL;
                        end else begin
                            w_cmd_nxt     = {r_cmd[1:0], w_din};
                            w_bit_cnt_nxt = r_bit_cnt + 4'd1;
                        end
                    end
                end

                S_NULL: begin
                    if (w_sclk_fall) begin
                        w_dout_nxt    = 1'b0;
                        w_oe_nxt      = 1'b1;
                        w_bit_cnt_nxt = '0;
                        w_state_nxt   = S_DATA;
                    end
                end

                S_DATA: begin
                    if (w_sclk_fall) begin
                        w_dout_nxt  = r_shift[11];
                        w_shift_nxt = {r_shift[10:0], 1'b0};
                        if (r_bit_cnt == 4'd11) begin
                            w_bit_cnt_nxt = '0;
                            w_state_nxt   = S_TRAIL;
                        end else begin
                            w_bit_cnt_nxt = r_bit_cnt + 4'd1;
                        end
                    end
                end

                S_TRAIL: begin
                    // B0 stays on the pin until the fall that follows it.
                    if (w_sclk_fall) begin
                        w_dout_nxt = 1'b0;
                    end
                end

                default: begin
                    w_state_nxt   = S_IDLE;
                    w_bit_cnt_nxt = '0;
                    w_dout_nxt    = 1'b0;
                    w_oe_nxt      = 1'b0;
                end
            endcase
        end
    end

    // ---------------------------------------------------------------
    // Outputs
    // ---------------------------------------------------------------
    // sample_req is decoded from registered signals. sample_data is
    // therefore captured at the end of the same clk in which the request
    // is high.
    assign sample_req  = w_sample_req;
    assign spi_dout    = r_dout;
    assign spi_dout_oe = r_oe;
    assign ch_sel      = r_ch_sel;
    assign sgl_diff    = r_sgl;
    assign busy        = (r_state != S_IDLE);
    assign frame_done  = r_done;
    assign frame_err   = r_err;

endmodule

// File: tb/tb_adc_spi_responder.sv
// Self-checking bench for adc_spi_responder: SPI master model at clk:SCLK = 8,
// table-driven frames, hand-written abort/reset/back-to-back sequences and
// randomly phase-shifted random frames.
`timescale 1ns/1ps

module tb_adc_spi_responder;

    localparam real HALF = 40.0;    // SCLK half period = 4 clk periods

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        spi_sclk = 1'b0;
    logic        spi_cs_n = 1'b1;
    logic        spi_din = 1'b0;
    logic [11:0] sample_data = 12'h000;
    logic        spi_dout;
    logic        spi_dout_oe;
    logic [2:0]  ch_sel;
    logic        sgl_diff;
    logic        sample_req;
    logic        busy;
    logic        frame_done;
    logic        frame_err;

    adc_spi_responder #(.SYNC_STAGES(2)) dut (
        .clk         (clk),
        .rst         (rst),
        .spi_sclk    (spi_sclk),
        .spi_cs_n    (spi_cs_n),
        .spi_din     (spi_din),
        .spi_dout    (spi_dout),
        .spi_dout_oe (spi_dout_oe),
        .ch_sel      (ch_sel),
        .sgl_diff    (sgl_diff),
        .sample_req  (sample_req),
        .sample_data (sample_data),
        .busy        (busy),
        .frame_done  (frame_done),
        .frame_err   (frame_err)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    // Pulse counters sampled on the falling clk edge, and the ADC model:
    // the conversion result is presented only in the sample_req clk.
    // Every other clk carries random junk.
    int          n_sreq = 0;
    int          n_done = 0;
    int          n_err  = 0;
    int          n_busy = 0;
    logic [11:0] g_sdata = 12'h000;

    always @(negedge clk) begin
        if (sample_req === 1'b1) n_sreq++;
        if (frame_done === 1'b1) n_done++;
        if (frame_err === 1'b1)  n_err++;
        if (busy === 1'b1)       n_busy++;
        sample_data = (sample_req === 1'b1) ? g_sdata : 12'($urandom);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // One SPI frame as the master sees it. Bit i: lead zeros, start, SGL,
    // D2, D1, D0, then zeros while reading. Extra clocks beyond the 18th
    // send din=1. rd[12] is the null bit and rd[11:0] holds B11..B0.
    task automatic do_frame(input int lead, input logic [3:0] cmd, input logic [11:0] sdata,
                            input int nclk, input real ph, input bit raise_cs,
                            output logic [12:0] rd, output int oe_bad, output int extra_bad);
        logic b;
        int   j;
        rd        = '0;
        oe_bad    = 0;
        extra_bad = 0;
        g_sdata   = sdata;
        @(posedge clk);
        #(ph);
        spi_cs_n = 1'b0;
        for (int i = 0; i < nclk; i++) begin
            if (i < lead)            b = 1'b0;
            else if (i == lead)      b = 1'b1;
            else if (i <= lead + 4)  b = cmd[lead + 4 - i];
            else if (i < lead + 18)  b = 1'b0;
            else                     b = 1'b1;
            spi_din = b;
            #(HALF);
            j = i - (lead + 5);
            if (j >= 0 && j <= 12) begin
                rd[12 - j] = spi_dout;
                if (spi_dout_oe !== 1'b1) oe_bad++;
            end else if (j > 12) begin
                if (spi_dout !== 1'b0 || spi_dout_oe !== 1'b1) extra_bad++;
            end
            spi_sclk = 1'b1;
            #(HALF);
            spi_sclk = 1'b0;
        end
        spi_din = 1'b0;
        if (raise_cs) begin
            #(HALF);
            spi_cs_n = 1'b1;
            #(4.0 * HALF);
        end
    endtask

    typedef struct {
        int          lead;
        logic [3:0]  cmd;      // {SGL, D2, D1, D0}
        logic [11:0] data;
        int          extra;
        logic [2:0]  exp_ch;
        logic        exp_sgl;
        logic [12:0] exp_rd;
    } vec_t;

    vec_t vecs[5];

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [12:0] rd;
        int          oe_bad, extra_bad;
        int          s0, d0, e0, b0;
        logic [3:0]  rcmd;
        logic [11:0] rdata;
        int          rlead;
        real         ph;

        vecs[0] = '{5, 4'b1011, 12'hA5C, 0, 3'd3, 1'b1, 13'h0A5C};
        vecs[1] = '{0, 4'b0111, 12'hFFF, 4, 3'd7, 1'b0, 13'h0FFF};
        vecs[2] = '{2, 4'b0000, 12'h001, 0, 3'd0, 1'b0, 13'h0001};
        vecs[3] = '{1, 4'b1110, 12'h800, 2, 3'd6, 1'b1, 13'h0800};
        vecs[4] = '{3, 4'b0101, 12'h3C7, 0, 3'd5, 1'b0, 13'h03C7};

        // Reset values while rst is held.
        repeat (3) @(posedge clk);
        #1;
        chk("rst_dout",    32'(spi_dout),    32'd0);
        chk("rst_oe",      32'(spi_dout_oe), 32'd0);
        chk("rst_ch_sel",  32'(ch_sel),      32'd0);
        chk("rst_sgl",     32'(sgl_diff),    32'd0);
        chk("rst_flags",   32'({sample_req, busy, frame_done, frame_err}), 32'd0);
        rst = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("idle_busy", 32'(busy), 32'd0);

        // Table-driven complete frames.
        foreach (vecs[k]) begin
            s0 = n_sreq; d0 = n_done; e0 = n_err;
            do_frame(vecs[k].lead, vecs[k].cmd, vecs[k].data, vecs[k].lead + 18 + vecs[k].extra,
                     3.0, 1'b1, rd, oe_bad, extra_bad);
            chk($sformatf("v%0d_read", k),   32'(rd),       32'(vecs[k].exp_rd));
            chk($sformatf("v%0d_ch_sel", k), 32'(ch_sel),   32'(vecs[k].exp_ch));
            chk($sformatf("v%0d_sgl", k),    32'(sgl_diff), 32'(vecs[k].exp_sgl));
            chk($sformatf("v%0d_sreq", k),   32'(n_sreq - s0), 32'd1);
            chk($sformatf("v%0d_done", k),   32'(n_done - d0), 32'd1);
            chk($sformatf("v%0d_err", k),    32'(n_err - e0),  32'd0);
            chk($sformatf("v%0d_oe_bad", k), 32'(oe_bad),      32'd0);
            chk($sformatf("v%0d_trail", k),  32'(extra_bad),   32'd0);
            chk($sformatf("v%0d_end", k),    32'({busy, spi_dout_oe, spi_dout}), 32'd0);
        end

        // Abort after B7 of 12'h800.
        s0 = n_sreq; d0 = n_done; e0 = n_err;
        do_frame(2, 4'b1100, 12'h800, 13, 3.0, 1'b0, rd, oe_bad, extra_bad);
        chk("abort_partial_read", 32'(rd[12:7]), 32'b010000);
        #(HALF);
        spi_cs_n = 1'b1;
        #(HALF);
        chk("abort_err",  32'(n_err - e0),  32'd1);
        chk("abort_done", 32'(n_done - d0), 32'd0);
        chk("abort_sreq", 32'(n_sreq - s0), 32'd1);
        chk("abort_oe",   32'(spi_dout_oe), 32'd0);
        chk("abort_dout", 32'(spi_dout),    32'd0);
        chk("abort_busy", 32'(busy),        32'd0);
        #(3.0 * HALF);

        // Reset in the middle of DATA while cs_n stays low.
        do_frame(0, 4'b0110, 12'h5A5, 12, 3.0, 1'b0, rd, oe_bad, extra_bad);
        chk("mid_ch_sel", 32'(ch_sel), 32'd6);
        #20;
        rst = 1'b1;
        #25;
        chk("mid_rst_dout_oe", 32'({spi_dout, spi_dout_oe}), 32'd0);
        chk("mid_rst_cfg",     32'({ch_sel, sgl_diff}), 32'd0);
        chk("mid_rst_flags",   32'({sample_req, busy, frame_done, frame_err}), 32'd0);
        rst = 1'b0;
        s0 = n_sreq; d0 = n_done; e0 = n_err; b0 = n_busy;
        // A cs_n still low from before reset must not open a frame.
        for (int i = 0; i < 8; i++) begin
            spi_din = 1'b1;
            #(HALF);
            spi_sclk = 1'b1;
            #(HALF);
            spi_sclk = 1'b0;
        end
        spi_din = 1'b0;
        chk("post_rst_busy", 32'(n_busy - b0), 32'd0);
        chk("post_rst_sreq", 32'(n_sreq - s0), 32'd0);
        spi_cs_n = 1'b1;
        #(4.0 * HALF);
        chk("post_rst_err", 32'(n_err - e0), 32'd0);
        do_frame(1, 4'b1010, 12'h6B3, 19, 3.0, 1'b1, rd, oe_bad, extra_bad);
        chk("post_rst_read", 32'(rd),       32'h06B3);
        chk("post_rst_ch",   32'(ch_sel),   32'd2);
        chk("post_rst_sgl",  32'(sgl_diff), 32'd1);
        chk("post_rst_done", 32'(n_done - d0), 32'd1);

        // Back-to-back frames: ch0 then ch5.
        s0 = n_sreq; d0 = n_done;
        do_frame(1, 4'b1000, 12'h123, 19, 3.0, 1'b1, rd, oe_bad, extra_bad);
        chk("b2b_a_read", 32'(rd),     32'h0123);
        chk("b2b_a_ch",   32'(ch_sel), 32'd0);
        do_frame(1, 4'b1101, 12'hABC, 19, 3.0, 1'b1, rd, oe_bad, extra_bad);
        chk("b2b_b_read", 32'(rd),     32'h0ABC);
        chk("b2b_b_ch",   32'(ch_sel), 32'd5);
        chk("b2b_sreq",   32'(n_sreq - s0), 32'd2);
        chk("b2b_done",   32'(n_done - d0), 32'd2);

        // 100 random frames with a random SCLK phase against clk.
        s0 = n_sreq; d0 = n_done; e0 = n_err;
        for (int f = 0; f < 100; f++) begin
            rlead = int'($urandom_range(0, 3));
            rcmd  = 4'($urandom);
            rdata = 12'($urandom);
            ph    = 0.1 * real'($urandom_range(5, 95));
            do_frame(rlead, rcmd, rdata, rlead + 18, ph, 1'b1, rd, oe_bad, extra_bad);
            chk($sformatf("rnd%0d_read", f), 32'(rd), 32'({1'b0, rdata}));
            chk($sformatf("rnd%0d_cfg", f),  32'({sgl_diff, ch_sel}), 32'(rcmd));
            chk($sformatf("rnd%0d_oe_bad", f), 32'(oe_bad), 32'd0);
        end
        chk("rnd_sreq", 32'(n_sreq - s0), 32'd100);
        chk("rnd_done", 32'(n_done - d0), 32'd100);
        chk("rnd_err",  32'(n_err - e0),  32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
